// File: rtl/imm_dec_ctrl.sv
// Decode-stage controller for RV32I: classifies opcodes, drives the immediate
// generator select and holds decoded entries in a 2-deep skid-buffered ID/EX register.
module imm_dec_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    input  logic [31:0]      if_pc,
    output logic             if_ready,
    input  logic             flush,
    output logic [31:0]      ig_instr,
    output logic [2:0]       ig_ext_op,
    input  logic [31:0]      ig_imm,
    output logic             id_valid,
    input  logic             ex_ready,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_imm,
    output logic [4:0]       id_rd,
    output logic [2:0]       id_ext_op,
    output logic             id_illegal,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic [1:0]       dbgState
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } bufState_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [2:0]  extOp;
        logic        illegal;
    } entry_t;

    bufState_t state;
    entry_t    outReg;
    entry_t    skidReg;
    entry_t    newEntry;
    logic [2:0] decExtOp;
    logic       decIllegal;
    logic       decNoImm;
    logic       accept;
    logic       consume;

    always_comb begin
        decExtOp   = 3'b000;
        decIllegal = 1'b0;
        decNoImm   = 1'b0;
        case (if_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111,
            7'b1110011, 7'b0001111: decExtOp = 3'b000;
            7'b0110111, 7'b0010111: decExtOp = 3'b001;
            7'b0100011:             decExtOp = 3'b010;
            7'b1100011:             decExtOp = 3'b011;
            7'b1101111:             decExtOp = 3'b100;
            7'b0110011:             decNoImm = 1'b1;
            default:                decIllegal = 1'b1;
        endcase
    end

    assign ig_instr  = if_instr;
    assign ig_ext_op = decExtOp;

    assign newEntry.pc      = if_pc;
    assign newEntry.imm     = (decIllegal || decNoImm) ? 32'd0 : ig_imm;
    assign newEntry.rd      = if_instr[11:7];
    assign newEntry.extOp   = decExtOp;
    assign newEntry.illegal = decIllegal;

    // Transfer on either side happens only in a cycle where valid and ready are
    // both high at the clock edge; flush vetoes the fetch-side transfer.
    assign accept  = if_valid & if_ready & ~flush;
    assign consume = id_valid & ex_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= EMPTY;
            outReg      <= '0;
            skidReg     <= '0;
            id_valid    <= 1'b0;
            if_ready    <= 1'b1;
            illegal_cnt <= '0;
        end else begin
            if (flush) begin
                state    <= EMPTY;
                id_valid <= 1'b0;
                if_ready <= 1'b1;
            end else begin
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            outReg   <= newEntry;
                            state    <= ONE;
                            id_valid <= 1'b1;
                        end
                    end
                    ONE: begin
                        if (accept && consume) begin
                            outReg <= newEntry;
                        end else if (accept) begin
                            skidReg  <= newEntry;
                            state    <= TWO;
                            if_ready <= 1'b0;
                        end else if (consume) begin
                            state    <= EMPTY;
                            id_valid <= 1'b0;
                        end
                    end
                    TWO: begin
                        if (consume) begin
                            outReg   <= skidReg;
                            state    <= ONE;
                            if_ready <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= EMPTY;
                        id_valid <= 1'b0;
                        if_ready <= 1'b1;
                    end
                endcase
            end
            if (accept && decIllegal && (illegal_cnt != {CNT_W{1'b1}}))
                illegal_cnt <= illegal_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign id_pc      = outReg.pc;
    assign id_imm     = outReg.imm;
    assign id_rd      = outReg.rd;
    assign id_ext_op  = outReg.extOp;
    assign id_illegal = outReg.illegal;
    assign dbgState   = state;

endmodule
